// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath select lines from the internal instruction register, counts retired
// instructions and halts in TRAP on an illegal opcode or a memory timeout.
module multicycle_controller #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  input  logic             BrEq,
  input  logic             BrLT,
  input  logic             trap_clr,
  output logic             PCSel,
  output logic [2:0]       ImmSel,
  output logic             RegWEn,
  output logic             BrUn,
  output logic             ASel,
  output logic             BSel,
  output logic [3:0]       ALUSel,
  output logic [1:0]       MemRW,
  output logic [1:0]       WBSel,
  output logic             mem_req,
  output logic             addr_sel,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  state_t            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              trap_q, trap_d;
  logic [1:0]        cause_q, cause_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       isR, isOpImm, isLoad, isStore, isBranch, isJal, isJalr, isLui, isAuipc;
  logic       legal, altBit, brTaken, memTimeout;
  logic [2:0] aluImm;
  logic       aluA, aluB;
  logic [3:0] aluOp;
  logic       unusedIrBits;

  assign opcode   = ir_q[6:0];
  assign funct3   = ir_q[14:12];
  assign isR      = (opcode == 7'b0110011);
  assign isOpImm  = (opcode == 7'b0010011);
  assign isLoad   = (opcode == 7'b0000011);
  assign isStore  = (opcode == 7'b0100011);
  assign isBranch = (opcode == 7'b1100011);
  assign isJal    = (opcode == 7'b1101111);
  assign isJalr   = (opcode == 7'b1100111);
  assign isLui    = (opcode == 7'b0110111);
  assign isAuipc  = (opcode == 7'b0010111);
  assign legal    = isR | isOpImm | isLoad | isStore | isJal | isJalr | isLui | isAuipc |
                    (isBranch & (funct3 != 3'b010) & (funct3 != 3'b011));
  assign altBit   = isR ? ir_q[30] : ((funct3 == 3'b101) & ir_q[30]);
  assign memTimeout = (MEM_TIMEOUT != 0) && !mem_ready && (wait_q == WAIT_LAST);
  assign unusedIrBits = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  assign instret    = instret_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

  // Immediate format, operand selects and ALU operation for the instruction in IR
  always_comb begin
    aluImm = 3'b000;
    aluA   = 1'b0;
    aluB   = 1'b1;
    aluOp  = 4'd0;
    if (isR || isOpImm) begin
      aluB = isOpImm;
      if (isOpImm && (funct3 == 3'b001 || funct3 == 3'b101)) aluImm = 3'b101;
      case (funct3)
        3'b000:  aluOp = (isR && altBit) ? 4'd1 : 4'd0;
        3'b001:  aluOp = 4'd2;
        3'b010:  aluOp = 4'd3;
        3'b011:  aluOp = 4'd4;
        3'b100:  aluOp = 4'd5;
        3'b101:  aluOp = altBit ? 4'd7 : 4'd6;
        3'b110:  aluOp = 4'd8;
        default: aluOp = 4'd9;
      endcase
    end else if (isStore) begin
      aluImm = 3'b001;
    end else if (isBranch) begin
      aluImm = 3'b010;
      aluA   = 1'b1;
    end else if (isJal) begin
      aluImm = 3'b011;
      aluA   = 1'b1;
    end else if (isJalr) begin
      aluOp  = 4'd10;
    end else if (isLui) begin
      aluImm = 3'b100;
      aluOp  = 4'd11;
    end else if (isAuipc) begin
      aluImm = 3'b100;
      aluA   = 1'b1;
    end
  end

  // Branch outcome from the comparator flags and the branch funct3
  always_comb begin
    case (funct3)
      3'b000:         brTaken = BrEq;
      3'b001:         brTaken = !BrEq;
      3'b100, 3'b110: brTaken = BrLT;
      3'b101, 3'b111: brTaken = !BrLT;
      default:        brTaken = 1'b0;
    endcase
  end

  // Datapath controls and strobes; reset suppresses every request and strobe
  always_comb begin
    PCSel    = 1'b0;
    ImmSel   = 3'b000;
    RegWEn   = 1'b0;
    BrUn     = 1'b0;
    ASel     = 1'b0;
    BSel     = 1'b0;
    ALUSel   = 4'd0;
    MemRW    = 2'b00;
    WBSel    = 2'b00;
    mem_req  = 1'b0;
    addr_sel = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    if (state_q inside {EXEC, MEM, WB}) begin
      ImmSel = aluImm;
      ASel   = aluA;
      BSel   = aluB;
      ALUSel = aluOp;
    end
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        MemRW   = 2'b10;
        IRWrite = mem_ready;
      end
      EXEC: begin
        if (isBranch) begin
          PCSel   = brTaken;
          BrUn    = funct3[2] & funct3[1];
          PCWrite = 1'b1;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        MemRW    = isStore ? 2'b01 : 2'b10;
        PCWrite  = isStore & mem_ready;
      end
      WB: begin
        RegWEn  = 1'b1;
        PCWrite = 1'b1;
        if (isLoad) begin
          WBSel = 2'b00;
        end else if (isJal || isJalr) begin
          WBSel = 2'b10;
          PCSel = 1'b1;
        end else begin
          WBSel = 2'b01;
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_req = 1'b0;
      MemRW   = 2'b00;
      IRWrite = 1'b0;
      PCWrite = 1'b0;
      RegWEn  = 1'b0;
    end
  end

  // Next state, IR load, retirement count, memory wait counter and trap status
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    wait_d    = '0;
    trap_d    = trap_q;
    cause_d   = cause_q;
    if (PCWrite) instret_d = instret_q + CNT_W'(1);
    case (state_q)
      FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = DECODE;
        end else if (memTimeout) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b10;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
        end
      end
      DECODE: begin
        if (legal) begin
          state_d = EXEC;
        end else begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b01;
        end
      end
      EXEC: begin
        if (isLoad || isStore) state_d = MEM;
        else if (isBranch)     state_d = FETCH;
        else                   state_d = WB;
      end
      MEM: begin
        if (mem_ready) begin
          state_d = isStore ? FETCH : WB;
        end else if (memTimeout) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b10;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
        end
      end
      WB: state_d = FETCH;
      TRAP: begin
        if (trap_clr) begin
          state_d = FETCH;
          trap_d  = 1'b0;
          cause_d = 2'b00;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Controller state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      instret_q <= '0;
      wait_q    <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      wait_q    <= wait_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller. Each instruction is expanded into
// its expected cycle sequence from the ISA-level rules; a negedge process compares
// every output against that expectation, plus a few hand-computed literal checks.
module tb_multicycle_controller;
  localparam int CNT_W = 4;
  localparam int TMO   = 4;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3,
                         A_SLTU = 4'd4, A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                         A_OR = 4'd8, A_AND = 4'd9, A_JALR = 4'd10, A_LUI = 4'd11;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] mem_rdata;
  logic mem_ready, BrEq, BrLT, trap_clr;
  logic PCSel, RegWEn, BrUn, ASel, BSel, mem_req, addr_sel, IRWrite, PCWrite, trap;
  logic [2:0] ImmSel;
  logic [3:0] ALUSel;
  logic [1:0] MemRW, WBSel, trap_cause;
  logic [CNT_W-1:0] instret;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .BrEq(BrEq), .BrLT(BrLT), .trap_clr(trap_clr), .PCSel(PCSel), .ImmSel(ImmSel),
    .RegWEn(RegWEn), .BrUn(BrUn), .ASel(ASel), .BSel(BSel), .ALUSel(ALUSel),
    .MemRW(MemRW), .WBSel(WBSel), .mem_req(mem_req), .addr_sel(addr_sel),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .trap(trap), .trap_cause(trap_cause),
    .instret(instret)
  );

  int checkCount = 0;
  int passCount  = 0;
  int retired    = 0;
  int litIdx     = 0;
  int brEqForce  = -1;
  int abortMemCycle = -1;
  logic chkEn = 1'b0;

  logic ePCSel, eRegWEn, eBrUn, eASel, eBSel, eMemReq, eAddrSel, eIRWrite, ePCWrite, eTrap;
  logic [2:0] eImmSel;
  logic [3:0] eALUSel;
  logic [1:0] eMemRW, eWBSel, eCause;
  logic [CNT_W-1:0] eInstret;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Single compare point: model expectations every cycle, literal pins on tagged cycles
  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("PCSel", 32'(PCSel), 32'(ePCSel));
      checkOutput("ImmSel", 32'(ImmSel), 32'(eImmSel));
      checkOutput("RegWEn", 32'(RegWEn), 32'(eRegWEn));
      checkOutput("BrUn", 32'(BrUn), 32'(eBrUn));
      checkOutput("ASel", 32'(ASel), 32'(eASel));
      checkOutput("BSel", 32'(BSel), 32'(eBSel));
      checkOutput("ALUSel", 32'(ALUSel), 32'(eALUSel));
      checkOutput("MemRW", 32'(MemRW), 32'(eMemRW));
      checkOutput("WBSel", 32'(WBSel), 32'(eWBSel));
      checkOutput("mem_req", 32'(mem_req), 32'(eMemReq));
      checkOutput("addr_sel", 32'(addr_sel), 32'(eAddrSel));
      checkOutput("IRWrite", 32'(IRWrite), 32'(eIRWrite));
      checkOutput("PCWrite", 32'(PCWrite), 32'(ePCWrite));
      checkOutput("trap", 32'(trap), 32'(eTrap));
      checkOutput("trap_cause", 32'(trap_cause), 32'(eCause));
      checkOutput("instret", 32'(instret), 32'(eInstret));
      case (litIdx)
        1: checkOutput("lit_first_fetch_mem_req", 32'(mem_req), 32'd1);
        2: begin
          checkOutput("lit_add_wb_ALUSel", 32'(ALUSel), 32'd0);
          checkOutput("lit_add_wb_WBSel", 32'(WBSel), 32'd1);
          checkOutput("lit_add_wb_RegWEn", 32'(RegWEn), 32'd1);
          checkOutput("lit_add_wb_PCWrite", 32'(PCWrite), 32'd1);
        end
        3: checkOutput("lit_instret_after_add", 32'(instret), 32'd1);
        4: begin
          checkOutput("lit_illegal_trap", 32'(trap), 32'd1);
          checkOutput("lit_illegal_cause", 32'(trap_cause), 32'd1);
          checkOutput("lit_illegal_instret", 32'(instret), 32'd1);
        end
        5: begin
          checkOutput("lit_clr_trap_low", 32'(trap), 32'd0);
          checkOutput("lit_clr_fetch_req", 32'(mem_req), 32'd1);
        end
        6: begin
          checkOutput("lit_timeout_cause", 32'(trap_cause), 32'd2);
          checkOutput("lit_timeout_req_dropped", 32'(mem_req), 32'd0);
        end
        7: checkOutput("lit_instret_wrap", 32'(instret), 32'd0);
        8: begin
          checkOutput("lit_bne_taken_PCSel", 32'(PCSel), 32'd1);
          checkOutput("lit_bne_taken_PCWrite", 32'(PCWrite), 32'd1);
        end
        9: begin
          checkOutput("lit_bne_not_taken_PCSel", 32'(PCSel), 32'd0);
          checkOutput("lit_bne_not_taken_PCWrite", 32'(PCWrite), 32'd1);
        end
        10: begin
          checkOutput("lit_lw_mem_req", 32'(mem_req), 32'd1);
          checkOutput("lit_lw_addr_sel", 32'(addr_sel), 32'd1);
          checkOutput("lit_lw_MemRW", 32'(MemRW), 32'd2);
        end
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle expectation for a cycle plus random values on every input that should not matter
  task automatic applyStimulus();
    ePCSel = 0; eImmSel = 0; eRegWEn = 0; eBrUn = 0; eASel = 0; eBSel = 0;
    eALUSel = 0; eMemRW = 0; eWBSel = 0; eMemReq = 0; eAddrSel = 0;
    eIRWrite = 0; ePCWrite = 0; eTrap = 0; eCause = 0;
    eInstret = CNT_W'(retired);
    litIdx = 0;
    mem_rdata = $urandom;
    mem_ready = 1'($urandom);
    trap_clr  = 1'($urandom);
    BrEq      = 1'($urandom);
    BrLT      = 1'($urandom);
  endtask

  function automatic logic [3:0] opAlu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? A_SUB : A_ADD;
      3'b001:  return A_SLL;
      3'b010:  return A_SLT;
      3'b011:  return A_SLTU;
      3'b100:  return A_XOR;
      3'b101:  return alt ? A_SRA : A_SRL;
      3'b110:  return A_OR;
      default: return A_AND;
    endcase
  endfunction

  // Expected immediate format, operand selects and ALU op straight from the ISA table
  task automatic setAluExpect(input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    case (ins[6:0])
      7'b0110011: begin eImmSel = 3'b000; eASel = 0; eBSel = 0; eALUSel = opAlu(f3, ins[30]); end
      7'b0010011: begin
        eImmSel = (f3 == 3'b001 || f3 == 3'b101) ? 3'b101 : 3'b000;
        eASel = 0; eBSel = 1;
        eALUSel = opAlu(f3, (f3 == 3'b101) ? ins[30] : 1'b0);
      end
      7'b0000011: begin eImmSel = 3'b000; eASel = 0; eBSel = 1; eALUSel = A_ADD; end
      7'b0100011: begin eImmSel = 3'b001; eASel = 0; eBSel = 1; eALUSel = A_ADD; end
      7'b1100011: begin eImmSel = 3'b010; eASel = 1; eBSel = 1; eALUSel = A_ADD; end
      7'b1101111: begin eImmSel = 3'b011; eASel = 1; eBSel = 1; eALUSel = A_ADD; end
      7'b1100111: begin eImmSel = 3'b000; eASel = 0; eBSel = 1; eALUSel = A_JALR; end
      7'b0110111: begin eImmSel = 3'b100; eASel = 0; eBSel = 1; eALUSel = A_LUI; end
      default:    begin eImmSel = 3'b100; eASel = 1; eBSel = 1; eALUSel = A_ADD; end
    endcase
  endtask

  // Run one instruction from its first fetch cycle; cause reports 01/10 trap, 11 reset abort
  task automatic doInstr(input logic [31:0] ins, input int fetchWait, input int memWait,
                         input int fetchLit, input int execLit, input int memLit, input int wbLit,
                         output logic [1:0] cause);
    logic [6:0] op;
    logic [2:0] f3;
    logic isLoad, isStore, isBr, isJump, legal, eq, lt;
    op = ins[6:0];
    f3 = ins[14:12];
    isLoad  = (op == 7'b0000011);
    isStore = (op == 7'b0100011);
    isBr    = (op == 7'b1100011);
    isJump  = (op == 7'b1101111) || (op == 7'b1100111);
    legal   = (op inside {7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111}) &&
              !(isBr && (f3 == 3'b010 || f3 == 3'b011));
    cause = 2'b00;
    for (int k = 0; k < 64; k++) begin
      applyStimulus();
      eMemReq = 1; eMemRW = 2'b10;
      if (k == 0) litIdx = fetchLit;
      if (k < fetchWait) begin
        mem_ready = 0;
        tick();
        if (k == TMO - 1) begin cause = 2'b10; return; end
      end else begin
        mem_ready = 1; mem_rdata = ins; eIRWrite = 1;
        tick();
        break;
      end
    end
    applyStimulus();
    tick();
    if (!legal) begin cause = 2'b01; return; end
    applyStimulus();
    setAluExpect(ins);
    eq = (brEqForce < 0) ? 1'($urandom) : 1'(brEqForce);
    lt = 1'($urandom);
    BrEq = eq; BrLT = lt;
    litIdx = execLit;
    if (isBr) begin
      ePCWrite = 1;
      eBrUn = (f3 == 3'b110) || (f3 == 3'b111);
      case (f3)
        3'b000:  ePCSel = eq;
        3'b001:  ePCSel = !eq;
        3'b100, 3'b110: ePCSel = lt;
        default: ePCSel = !lt;
      endcase
    end
    tick();
    if (isBr) begin retired++; return; end
    if (isLoad || isStore) begin
      for (int k = 0; k < 64; k++) begin
        if (k == abortMemCycle) begin
          retired = 0;
          applyStimulus(); rst_n = 0; tick();
          applyStimulus(); tick();
          rst_n = 1; cause = 2'b11;
          return;
        end
        applyStimulus();
        setAluExpect(ins);
        eMemReq = 1; eAddrSel = 1; eMemRW = isLoad ? 2'b10 : 2'b01;
        litIdx = memLit;
        if (k < memWait) begin
          mem_ready = 0;
          tick();
          if (k == TMO - 1) begin cause = 2'b10; return; end
        end else begin
          mem_ready = 1;
          if (isStore) ePCWrite = 1;
          tick();
          if (isStore) begin retired++; return; end
          break;
        end
      end
    end
    applyStimulus();
    setAluExpect(ins);
    eRegWEn = 1; ePCWrite = 1;
    eWBSel = isLoad ? 2'b00 : (isJump ? 2'b10 : 2'b01);
    ePCSel = isJump;
    litIdx = wbLit;
    tick();
    retired++;
  endtask

  // Sit in TRAP for holdCycles with trap_clr low, then release it with one trap_clr pulse
  task automatic doTrap(input logic [1:0] cause, input int holdCycles, input int firstLit);
    for (int k = 0; k < holdCycles; k++) begin
      applyStimulus();
      eTrap = 1; eCause = cause; trap_clr = 0;
      if (k == 0) litIdx = firstLit;
      tick();
    end
    applyStimulus();
    eTrap = 1; eCause = cause; trap_clr = 1;
    if (holdCycles == 0) litIdx = firstLit;
    tick();
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    logic [6:0] op;
    r = $urandom;
    case ($urandom_range(0, 10))
      0: op = 7'b0110011;
      1: op = 7'b0000011;
      2: op = 7'b0010011;
      3: op = 7'b0100011;
      4: op = 7'b1100011;
      5: op = 7'b1101111;
      6: op = 7'b1100111;
      7: op = 7'b0110111;
      8: op = 7'b0010111;
      9: op = 7'b0010011;
      default: op = r[6:0];
    endcase
    return {r[31:7], op};
  endfunction

  function automatic int randWait();
    return ($urandom_range(0, 7) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
  endfunction

  initial begin
    logic [1:0] c;
    logic [31:0] ins;
    int fw, mw;
    rst_n = 0;
    chkEn = 1;
    applyStimulus(); tick();
    applyStimulus(); tick();
    applyStimulus(); tick();
    rst_n = 1;

    doInstr(32'h002081B3, 0, 0, 1, 0, 0, 2, c);
    doInstr(32'h0000007F, 0, 0, 3, 0, 0, 0, c);
    doTrap(c, 2, 4);
    doInstr(32'h00100093, 0, 0, 5, 0, 0, 0, c);
    doInstr(32'h0000A103, 1, 3, 0, 0, 10, 0, c);
    brEqForce = 0;
    doInstr(32'h00209463, 0, 0, 0, 8, 0, 0, c);
    brEqForce = 1;
    doInstr(32'h00209463, 2, 0, 0, 9, 0, 0, c);
    brEqForce = -1;
    doInstr(32'h0020A023, 0, 2, 0, 0, 0, 0, c);
    doInstr(32'h008000EF, 0, 0, 0, 0, 0, 0, c);
    doInstr(32'h000080E7, 1, 0, 0, 0, 0, 0, c);
    doInstr(32'h123450B7, 0, 0, 0, 0, 0, 0, c);
    doInstr(32'h00001097, 0, 0, 0, 0, 0, 0, c);
    doInstr(32'h4010D093, 0, 0, 0, 0, 0, 0, c);
    doInstr(32'h40208133, 0, 0, 0, 0, 0, 0, c);
    doInstr(32'h0020E463, 0, 0, 0, 0, 0, 0, c);
    doInstr(32'h0020F463, 0, 0, 0, 0, 0, 0, c);
    doInstr(32'h0020A463, 0, 0, 0, 0, 0, 0, c);
    doTrap(c, 1, 0);
    doInstr(32'h00100093, 6, 0, 0, 0, 0, 0, c);
    doTrap(c, 0, 6);
    doInstr(32'h0000A103, 0, 7, 0, 0, 0, 0, c);
    doTrap(c, 1, 0);
    abortMemCycle = 1;
    doInstr(32'h0000A103, 0, 5, 0, 0, 0, 0, c);
    abortMemCycle = -1;
    for (int i = 0; i < 16; i++) doInstr(32'h00100093, 0, 0, 0, 0, 0, 0, c);
    doInstr(32'h00100093, 0, 0, 7, 0, 0, 0, c);

    for (int n = 0; n < 300; n++) begin
      ins = randInstr();
      fw = randWait();
      mw = randWait();
      doInstr(ins, fw, mw, 0, 0, 0, 0, c);
      if (c == 2'b01 || c == 2'b10) doTrap(c, $urandom_range(0, 3), 0);
    end

    chkEn = 0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, maximum wait cycles for mem_ready; 0 disables the timeout.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_rdata  in  32  instruction word from memory, valid when mem_ready=1 in FETCH.
- mem_ready  in  1  memory completed the current request.
- BrEq  in  1  rs1==rs2.
- BrLT  in  1  rs1<rs2, signedness per BrUn.
- trap_clr  in  1  acknowledge trap, resume fetch.
- PCSel  out  1  0=PC+4, 1=ALU result.
- ImmSel  out  3  I=000, S=001, B=010, J=011, U=100, shamt=101.
- RegWEn  out  1  register-file write strobe.
- BrUn  out  1  unsigned compare.
- ASel  out  1  0=rs1, 1=PC.
- BSel  out  1  0=rs2, 1=immediate.
- ALUSel  out  4  add 0, sub 1, sll 2, slt 3, sltu 4, xor 5, srl 6, sra 7, or 8, and 9, jalr 10, lui 11.
- MemRW  out  2  00 idle, 10 read, 01 write.
- WBSel  out  2  00 mem, 01 ALU, 10 PC+4.
- mem_req  out  1  memory request valid.
- addr_sel  out  1  memory address: 0=PC, 1=ALU result.
- IRWrite  out  1  instruction-register load strobe.
- PCWrite  out  1  PC update strobe.
- trap  out  1  controller halted on fault.
- trap_cause  out  2  01 illegal opcode, 10 memory timeout.
- instret  out  CNT_W  retired-instruction count.

Function
REQ-004 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-005 SHALL hold an internal 32-bit IR, loaded from mem_rdata when IRWrite=1; all decoding uses IR.
REQ-006 FETCH SHALL drive mem_req=1, MemRW=10, addr_sel=0; on mem_ready it SHALL pulse IRWrite for that cycle and go to DECODE.
REQ-007 DECODE SHALL last one cycle; an opcode outside {0110011, 0000011, 0010011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111} SHALL go to TRAP with cause 01; otherwise it SHALL go to EXEC.
REQ-008 EXEC SHALL drive ImmSel/ASel/BSel/ALUSel per RV32I: R-type from {funct3, IR[30]}; OP-IMM with IR[30] applied only to funct3=101; loads, stores and AUIPC use add; LUI uses lui; JALR uses jalr; JAL and branches use add with ASel=1.
REQ-009 EXEC exits: load/store to MEM; branch to FETCH with PCWrite=1; all other opcodes to WB.
REQ-010 Branch PCSel SHALL be evaluated in EXEC: BEQ=BrEq, BNE=!BrEq, BLT/BLTU=BrLT, BGE/BGEU=!BrLT; BrUn=1 only for BLTU/BGEU; funct3 010/011 SHALL be treated as illegal (TRAP, cause 01).
REQ-011 MEM SHALL drive mem_req=1, addr_sel=1, MemRW=10 for loads and 01 for stores, holding ALU controls from EXEC; on mem_ready a load SHALL go to WB, and a store SHALL go to FETCH with PCWrite=1, PCSel=0.
REQ-012 WB SHALL last one cycle with RegWEn=1 and PCWrite=1; WBSel=00 for loads, 10 with PCSel=1 for JAL/JALR, 01 with PCSel=0 otherwise.
REQ-013 RegWEn, PCWrite, IRWrite and mem_req SHALL be 0 in every state and cycle not named above.
REQ-014 instret SHALL increment by 1 on each cycle with PCWrite=1, wrapping modulo 2^CNT_W.
REQ-015 With MEM_TIMEOUT>0, a wait counter SHALL clear on entering FETCH or MEM and count cycles with mem_ready=0; reaching MEM_TIMEOUT SHALL go to TRAP with cause 10 and drop mem_req the next cycle.
REQ-016 TRAP SHALL hold trap=1 and trap_cause, with no strobes; trap_clr=1 SHALL return to FETCH without a PC update and clear trap in that same transition.
REQ-017 mem_ready outside FETCH/MEM, and trap_clr outside TRAP, SHALL be ignored.

Reset
REQ-018 rst_n=0 SHALL asynchronously force state FETCH, IR=0, instret=0, wait counter=0, trap=0, trap_cause=00.
REQ-019 After rst_n rises, FETCH SHALL assert mem_req in the first cycle; reset asserted mid-transfer SHALL abort it with no strobes.

Verification
REQ-020 ADD x3,x1,x2 (0x002081B3) with mem_ready in cycle 1 -> states FETCH, DECODE, EXEC, WB; ALUSel=0, WBSel=01, RegWEn=1 and PCWrite=1 in WB; instret=1.
REQ-021 LW with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, addr_sel=1, MemRW=10, then WB with WBSel=00.
REQ-022 BNE with BrEq=0 -> PCSel=1, PCWrite=1 in EXEC; repeated with BrEq=1 -> PCSel=0.
REQ-023 Opcode 0x7F -> TRAP, trap_cause=01, instret unchanged; trap_clr pulse -> FETCH next cycle.
REQ-024 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 cycles, cause 10.
REQ-025 CNT_W=4, 16 retirements -> instret wraps to 0.
